gru_seq_cell: RTL
=================

# gru_seq_cell

Sequential, parametrised GRU cell holding a HID-element hidden-state vector and consuming INW-element input vectors one timestep at a time. It computes one timestep with a single time-multiplexed signed MAC and the team's combinational `sigmoid_lut` and `tanh_lut` instances. It has programmable weight/bias storage, valid/ready handshakes on input and output, and keeps the hidden state internally between timesteps. It sits between the feature front-end, which supplies x, and the classifier head, which consumes h.

## Interface
- N, 8: data width, signed fixed point.
- Q, 5: fraction bits; 1.0 = 2^Q.
- INW, 2: input vector length.
- HID, 4: hidden vector length.
- WAW, 7: weight address width; 2^WAW must be ≥ 3·HID·(INW+HID+1).
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- w_we  in  1  weight write strobe.
- w_addr  in  WAW  weight address.
- w_data  in  N  weight/bias value.
- state_clr  in  1  zero the hidden state.
- x_valid  in  1  input vector valid.
- x_ready  out  1  cell idle and able to accept x.
- x_data  in  INW·N  x[i] at bits [i·N +: N].
- h_valid  out  1  new hidden vector available.
- h_ready  in  1  consumer accepts h.
- h_data  out  HID·N  h[j] at bits [j·N +: N]; always reflects the stored state.
- busy  out  1  a timestep is in progress.

## Operation
- Equations, per unit j:
  - z = σ(Wz·x + Uz·h + bz)
  - r = σ(Wr·x + Ur·h + br)
  - c = tanh(Wh·x + Uh·(r⊙h) + bh)
  - h' = h + z·(c − h), which equals (1−z)h + zc.
- Weight map: gate g (0 = z, 1 = r, 2 = h), unit j, base = (g·HID + j)·(INW+HID+1).
  - Offsets 0..INW−1 hold W.
  - Offsets INW..INW+HID−1 hold U.
  - Offset INW+HID holds the bias.
- Writes apply only when the cell is not busy. A write while busy, or to an out-of-range address, is dropped.
- Arithmetic:
  - Products are 2N bits.
  - The accumulator is 2N + clog2(INW+HID+1) bits and starts at bias << Q.
  - The result is arithmetic-shifted right by Q (truncation toward −∞), then narrowed to N bits per the Configuration rule.
  - The r⊙h and z·(c−h) products are also shifted right by Q and narrowed the same way.
- FSM:
  - IDLE → ZG when x_valid & x_ready; x is latched.
  - ZG → RG → CG: each phase runs HID units × (INW+HID) MAC cycles plus one activation/store cycle.
  - RG also stores r⊙h into a scratch vector, which CG uses for its U terms.
  - CG → UPD: HID cycles, one h'[j] each. Writes go to a shadow vector, so every unit uses the old h.
  - UPD → OUT: the shadow is copied to h_data and h_valid is set.
  - OUT → IDLE on h_ready.
- x_ready = (state == IDLE) & ~h_valid. A new x is therefore never accepted until the previous output has been consumed.
- state_clr:
  - In IDLE, it zeroes h in the next cycle.
  - If it coincides with an x handshake, the timestep uses h = 0.
  - It is ignored when not in IDLE.
- h_valid stays high, and h_data stays stable, until h_ready.

## Timing
- Reset values:
  - x_ready = 1 (IDLE), h_valid = 0, busy = 0, h_data = 0.
  - All weights = 0; scratch and accumulator = 0.
- Latency: h_valid rises exactly 3·HID·(INW+HID+1) + HID + 1 cycles after the x handshake edge. With the defaults this is 89 cycles.
- busy is high from the cycle after the handshake until the cycle h_valid rises.
- The earliest next handshake is the cycle after the h_valid & h_ready edge. There is no back-to-back overlap.
- rst mid-timestep:
  - Returns to IDLE next cycle.
  - Discards the partial result.
  - Clears h and the weights.

## Configuration
- GRU_SATURATE_EN defined: every narrowing to N bits saturates to [−2^(N−1), 2^(N−1)−1].
- GRU_SATURATE_EN undefined: every narrowing keeps the low N bits (two's-complement wrap).
- LUT addressing is identical in both builds.

## Test plan
- All weights 0, x = {32, −32} → z = r = sigmoid_lut(0) (expected 16) and c = tanh_lut(0) = 0; h_data = 0; h_valid at cycle 89.
- Only bh = 32 for every unit, h initially 0 → every h[j] = (sigmoid_lut(0)·tanh_lut(32)) >> 5 after one step; a second step with the same x matches the model recomputed using the new h.
- Hold h_ready low for 20 cycles after h_valid, with x_valid high → x_ready stays 0, h_data is stable, no second handshake; release → exactly one handshake.
- All Wh = 127, bh = 127, x = {127, 127} → pre-activation clamps to 127 with GRU_SATURATE_EN; without it, it equals the low 8 bits of the exact sum, checked against the model.
- A w_we during busy changes nothing (readback via a subsequent all-zero-x step); state_clr with a concurrent handshake produces the h = 0 result.
- Assert rst at cycle 40 of a step → next cycle IDLE, h_valid = 0, h_data = 0, x_ready = 1.

Source files
------------

// File: rtl/gru_seq_cell.sv
// Sequential GRU cell: one timestep per x handshake, computed on a single shared signed multiplier.
// Define GRU_SATURATE_EN to saturate every narrowing to N bits; otherwise narrowing wraps.

module sigmoid_lut #(
  parameter int N = 8,
  parameter int Q = 5
) (
  input  logic signed [N-1:0] a,
  output logic signed [N-1:0] y
);
  // Hard sigmoid: clamp(a/4 + 0.5, 0, 1) in Q-format.
  always_comb begin
    int t;
    t = (int'(a) >>> 2) + (1 << (Q - 1));
    if (t < 0) t = 0;
    else if (t > (1 << Q)) t = 1 << Q;
    y = N'(t);
  end
endmodule

module tanh_lut #(
  parameter int N = 8,
  parameter int Q = 5
) (
  input  logic signed [N-1:0] a,
  output logic signed [N-1:0] y
);
  always_comb begin
    int t;
    t = int'(a);
    if (t < -(1 << Q)) t = -(1 << Q);
    else if (t > (1 << Q)) t = 1 << Q;
    y = N'(t);
  end
endmodule

module gru_seq_cell #(
  parameter int N   = 8,
  parameter int Q   = 5,
  parameter int INW = 2,
  parameter int HID = 4,
  parameter int WAW = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_we,
  input  logic [WAW-1:0]       w_addr,
  input  logic [N-1:0]         w_data,
  input  logic                 state_clr,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [INW*N-1:0]     x_data,
  output logic                 h_valid,
  input  logic                 h_ready,
  output logic [HID*N-1:0]     h_data,
  output logic                 busy
);
  localparam int ROW  = INW + HID + 1;
  localparam int NW   = 3 * HID * ROW;
  localparam int AW   = $clog2(NW);
  localparam int KW   = $clog2(ROW);
  localparam int HW   = $clog2(HID);
  localparam int IW   = $clog2(INW);
  localparam int ACCW = 2 * N + $clog2(ROW);
  localparam int PW   = 2 * N + 2;

  typedef enum logic [2:0] {IDLE, ZG, RG, CG, UPD, OUT} state_t;
  state_t state, state_nx;

  logic signed [N-1:0]    wmem [NW];
  logic signed [N-1:0]    xv [INW];
  logic signed [N-1:0]    h [HID];
  logic signed [N-1:0]    sh [HID];
  logic signed [N-1:0]    rh [HID];
  logic signed [N-1:0]    zv [HID];
  logic signed [N-1:0]    cv [HID];
  logic signed [ACCW-1:0] acc, mac_sum;
  logic [KW-1:0]          k;
  logic [HW-1:0]          unit;

  logic [1:0]             gate;
  logic [AW-1:0]          row_base;
  logic                   act_cyc;
  logic signed [N-1:0]    wsel, bsel, opnd, hk, pre, sig, tnh, pq, hnew;
  logic signed [N:0]      ma, mb;
  logic signed [PW-1:0]   prod;

  function automatic logic signed [N-1:0] narrow(input logic signed [31:0] v);
`ifdef GRU_SATURATE_EN
    if (v > 2**(N-1) - 1) return N'(2**(N-1) - 1);
    if (v < -(2**(N-1))) return N'(-(2**(N-1)));
`endif
    return N'(v);
  endfunction

  sigmoid_lut #(.N(N), .Q(Q)) u_sig  (.a(pre), .y(sig));
  tanh_lut    #(.N(N), .Q(Q)) u_tanh (.a(pre), .y(tnh));

  assign prod = ma * mb;

  // The one multiplier serves the MAC, the r*h scratch product and the z*(c-h) update.
  always_comb begin
    gate = 2'd0;
    if (state == RG) gate = 2'd1;
    else if (state == CG) gate = 2'd2;
    row_base = AW'((int'(gate) * HID + int'(unit)) * ROW);
    wsel     = wmem[row_base + AW'(k)];
    bsel     = wmem[row_base + AW'(ROW - 1)];
    act_cyc  = (state == ZG || state == RG || state == CG) && (int'(k) == ROW - 1);
    hk       = h[HW'(k)];
    if (int'(k) < INW) opnd = xv[IW'(k)];
    else if (state == CG) opnd = rh[HW'(int'(k) - INW)];
    else opnd = h[HW'(int'(k) - INW)];
    pre = narrow(32'(acc >>> Q));
    ma  = {wsel[N-1], wsel};
    mb  = {opnd[N-1], opnd};
    if (state == RG && act_cyc) begin
      ma = {sig[N-1], sig};
      mb = {h[unit][N-1], h[unit]};
    end
    if (state == UPD) begin
      ma = {zv[HW'(k)][N-1], zv[HW'(k)]};
      mb = {cv[HW'(k)][N-1], cv[HW'(k)]} - {hk[N-1], hk};
    end
    mac_sum = ((k == '0) ? (ACCW'(bsel) <<< Q) : acc) + ACCW'(prod);
    pq      = narrow(32'(prod >>> Q));
    hnew    = narrow(32'(hk) + 32'(pq));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (x_valid && x_ready) state_nx = ZG;
      ZG:   if (act_cyc && int'(unit) == HID - 1) state_nx = RG;
      RG:   if (act_cyc && int'(unit) == HID - 1) state_nx = CG;
      CG:   if (act_cyc && int'(unit) == HID - 1) state_nx = UPD;
      UPD:  if (int'(k) == HID) state_nx = OUT;
      OUT:  if (h_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      unit  <= '0;
      acc   <= '0;
      for (int unsigned i = 0; i < NW; i++) wmem[i] <= '0;
      for (int unsigned i = 0; i < INW; i++) xv[i] <= '0;
      for (int unsigned i = 0; i < HID; i++) begin
        h[i]  <= '0;
        sh[i] <= '0;
        rh[i] <= '0;
        zv[i] <= '0;
        cv[i] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (state_clr)
            for (int unsigned i = 0; i < HID; i++) h[i] <= '0;
          if (x_valid && x_ready) begin
            for (int unsigned i = 0; i < INW; i++) xv[i] <= x_data[i*N +: N];
            k    <= '0;
            unit <= '0;
          end
        end
        ZG, RG, CG: begin
          if (!act_cyc) begin
            acc <= mac_sum;
            k   <= k + 1'b1;
          end else begin
            if (state == ZG) zv[unit] <= sig;
            else if (state == RG) rh[unit] <= pq;
            else cv[unit] <= tnh;
            k    <= '0;
            unit <= (int'(unit) == HID - 1) ? '0 : unit + 1'b1;
          end
        end
        UPD: begin
          if (int'(k) < HID) begin
            sh[HW'(k)] <= hnew;
            k          <= k + 1'b1;
          end else begin
            h <= sh;
            k <= '0;
          end
        end
        default: ;
      endcase
      if (w_we && !busy && int'(w_addr) < NW) wmem[AW'(w_addr)] <= w_data;
    end
  end

  assign h_valid = (state == OUT);
  assign x_ready = (state == IDLE) && !h_valid;
  assign busy    = (state == ZG) || (state == RG) || (state == CG) || (state == UPD);

  always_comb begin
    h_data = '0;
    for (int unsigned j = 0; j < HID; j++) h_data[j*N +: N] = h[j];
  end
endmodule
